clk_ratio_meter: RTL and testbench
==================================

# clk_ratio_meter

Measures the division ratio of a divided clock against its source clock, the inverse of the programmable clock divider. The divided clock is sampled in the `i_ref_clk` domain and the reference cycles between consecutive rising edges are counted. The block reports each measured period and asserts lock once the ratio is stable. It sits beside the divider as a self-check and bring-up monitor.

## Interface
- `RATIO_WIDTH`, default 8: width of the measured ratio; max measurable ratio is 2^RATIO_WIDTH-2.
- `LOCK_COUNT`, default 4: number of consecutive identical measurements required for lock (≥2).
- `SYNC_STAGES`, default 2: synchronizer flops on `i_div_clk` (≥2).
- `i_ref_clk`, input, 1: reference clock. All logic runs on its rising edge.
- `i_rst`, input, 1: asynchronous, active-low reset.
- `i_meas_en`, input, 1: measurement enable. Low forces IDLE.
- `i_div_clk`, input, 1: divided clock under test, treated as asynchronous data.
- `o_ratio`, output, RATIO_WIDTH: last measured period in ref cycles.
- `o_ratio_valid`, output, 1: one-cycle pulse when `o_ratio` updates.
- `o_locked`, output, 1: ratio stable for `LOCK_COUNT` consecutive measurements.
- `o_timeout`, output, 1: sticky; no edge seen within the count range.
- `o_duty_err`, output, 1: one-cycle pulse with `o_ratio_valid` when the high time is wrong.

## Operation
- **Synchronizer:** `i_div_clk` passes through `SYNC_STAGES` flops, then one more flop for edge detect. `rise` = sync_out & ~prev.
- **FSM states:** IDLE, ARM, MEASURE, LOCKED.
  - IDLE: counters cleared. Go to ARM when `i_meas_en`=1.
  - ARM: wait for `rise`. On `rise`, period_cnt←1, high_cnt←0, go to MEASURE. No measurement is reported for this first edge.
  - MEASURE/LOCKED, cycles without `rise`: period_cnt+1, and high_cnt+1 when sync_out=1.
  - MEASURE/LOCKED, on `rise`: o_ratio←period_cnt and o_ratio_valid←1. Then period_cnt←1 and high_cnt←0 for the next period.
- **Lock counting:**
  - If the new value equals the previous measurement, match_cnt increments, saturating at LOCK_COUNT. Otherwise match_cnt←1.
  - The first measurement after ARM sets match_cnt←1.
  - Reaching LOCK_COUNT moves MEASURE→LOCKED.
  - Any mismatch moves LOCKED→MEASURE and clears o_locked in the same cycle o_ratio updates.
- **Timeout:** if period_cnt reaches 2^RATIO_WIDTH-1 without `rise`:
  - o_timeout←1 (sticky) and o_locked←0.
  - FSM goes to ARM.
  - o_ratio holds its last value.
  - o_timeout clears only on reset or when `i_meas_en` falls.
- **Enable low:** FSM goes to IDLE next cycle. o_locked←0 and o_timeout←0; o_ratio holds.
- **Unmeasurable ratios:** ratio 0/1 (divider passes `i_ref_clk` through, or output is constant) yields a timeout.
- **Minimum ratio:** 2, edge every 2 cycles, o_ratio=2.
- **Simultaneous `rise` and timeout threshold:** `rise` wins; the measurement is reported and there is no timeout.

## Timing
- **Reset values:** o_ratio=0, o_ratio_valid=0, o_locked=0, o_timeout=0, o_duty_err=0, FSM=IDLE, all counters 0.
- **Reset mid-measurement:** immediate clear, no pulse.
- **Latency:** a `i_div_clk` rise becomes `rise` after SYNC_STAGES+1 ref edges. o_ratio/o_ratio_valid update on the ref edge following `rise`.
- **Steady ratio N:** one o_ratio_valid pulse every N cycles.
- **Lock time:** o_locked asserts with the LOCK_COUNT-th consecutive equal valid pulse. From ARM that is LOCK_COUNT+1 divided edges.
- **Jitter:** ±1 cycle sampling jitter on an asynchronous input is reported as-is and breaks lock. Synchronous divided clocks measure exactly.

## Configuration
- **`CLK_RATIO_DUTY_CHECK_EN` defined:**
  - high_cnt is implemented.
  - On each measurement of N, o_duty_err pulses with o_ratio_valid if high_cnt ∉ {floor(N/2), ceil(N/2)}.
  - Odd ratios may alternate between these two values without error.
  - A duty error does not affect lock.
- **Not defined:** high_cnt is removed, and o_duty_err is tied to 0. The port is always present.

## Test plan
- Ratio 4, 50% duty, enable after reset → o_ratio=4 with valid every 4 cycles; o_locked=1 on the 4th pulse (LOCK_COUNT=4).
- Ratio 5, high time alternating 2/3 → o_ratio=5 every 5 cycles, o_locked=1, o_duty_err=0.
- Locked at 6, switch to 8 → first 8 measurement clears o_locked in the same cycle; relock after 4 measurements of 8.
- Hold `i_div_clk` low with RATIO_WIDTH=8 → o_timeout=1 when period_cnt reaches 255, o_locked=0, o_ratio holds 8. Drop `i_meas_en` → o_timeout=0.
- Period 6 with high time 1, macro on → o_duty_err pulses with each valid and o_ratio=6. Macro off → o_duty_err stays 0.
- Assert `i_rst` low mid-period while locked at 4 → all outputs 0 immediately. After release, the first valid arrives 2 edges later and reports 4.

Source files
------------

// File: rtl/clk_ratio_meter.sv
// ---------------------------------------------------------------------------
// clk_ratio_meter
//
// Measures the division ratio of a divided clock against the reference clock
// that produced it. The divided clock is treated as asynchronous data: it is
// synchronized into the i_ref_clk domain, rising edges are detected, and the
// number of reference cycles between consecutive rising edges is reported.
// Lock is declared once LOCK_COUNT consecutive measurements agree.
//
// Optional feature macro: CLK_RATIO_DUTY_CHECK_EN
//   Defined     : the high time of every measured period is counted and
//                 o_duty_err pulses alongside o_ratio_valid when the high
//                 time is neither floor(N/2) nor ceil(N/2).
//   Not defined : no high-time counter is built and o_duty_err is tied low.
//
// Parameters
//   RATIO_WIDTH  width of the measured ratio (max measurable 2^W-2)
//   LOCK_COUNT   consecutive identical measurements needed for lock (>=2)
//   SYNC_STAGES  synchronizer depth on i_div_clk (>=2)
//
// Ports
//   i_ref_clk      reference clock, all logic on its rising edge
//   i_rst          asynchronous reset, active low
//   i_meas_en      measurement enable, low forces IDLE
//   i_div_clk      divided clock under test (asynchronous)
//   o_ratio        last measured period in reference cycles
//   o_ratio_valid  one-cycle pulse when o_ratio updates
//   o_locked       ratio stable for LOCK_COUNT consecutive measurements
//   o_timeout      sticky, no edge seen within the count range
//   o_duty_err     one-cycle pulse with o_ratio_valid on a bad high time
// ---------------------------------------------------------------------------
module clk_ratio_meter #(
    parameter int RATIO_WIDTH = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_meas_en,
    input  logic                   i_div_clk,
    output logic [RATIO_WIDTH-1:0] o_ratio,
    output logic                   o_ratio_valid,
    output logic                   o_locked,
    output logic                   o_timeout,
    output logic                   o_duty_err
);

    localparam int MATCH_WIDTH = $clog2(LOCK_COUNT + 1);

    // Last value period_cnt may hold before a missing edge counts as a
    // timeout: one more cycle without an edge would take it to 2^W-1.
    localparam logic [RATIO_WIDTH-1:0] TIMEOUT_LAST = {{(RATIO_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [RATIO_WIDTH-1:0] PERIOD_ONE   = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MATCH_WIDTH-1:0] MATCH_ONE    = {{(MATCH_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MATCH_WIDTH-1:0] LOCK_MATCH   = MATCH_WIDTH'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED
    } state_t;

    state_t                   state_q;
    state_t                   state_d;

    logic [SYNC_STAGES-1:0]   sync_ff;
    logic                     sync_prev;
    logic                     sync_out;
    logic                     rise;

    logic [RATIO_WIDTH-1:0]   period_q;
    logic [RATIO_WIDTH-1:0]   period_d;
    logic [MATCH_WIDTH-1:0]   match_q;
    logic [MATCH_WIDTH-1:0]   match_d;
    logic [RATIO_WIDTH-1:0]   ratio_d;
    logic                     valid_d;
    logic                     timeout_d;

    // -----------------------------------------------------------------------
    // Synchronizer chain plus one extra flop so a rising edge can be seen
    // as "synchronized high now, was low one cycle ago".
    // -----------------------------------------------------------------------
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_ff   <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], i_div_clk};
            sync_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_ff[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_prev;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath decisions.
    //
    // ARM also counts cycles while waiting for the first edge, so a divided
    // clock that never toggles (ratio 0/1) still ends in a timeout instead
    // of leaving the block silently armed forever.
    //
    // match_q is zero only between ARM and the first measurement; that is
    // how the first measurement after arming is forced to a count of one
    // regardless of the stale o_ratio value.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        match_d   = match_q;
        ratio_d   = o_ratio;
        valid_d   = 1'b0;
        timeout_d = o_timeout;

        if (!i_meas_en) begin
            state_d   = IDLE;
            period_d  = '0;
            match_d   = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    period_d = '0;
                    match_d  = '0;
                    state_d  = ARM;
                end

                ARM: begin
                    if (rise) begin
                        period_d = PERIOD_ONE;
                        match_d  = '0;
                        state_d  = MEASURE;
                    end else if (period_q == TIMEOUT_LAST) begin
                        timeout_d = 1'b1;
                        period_d  = '0;
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end

                MEASURE, LOCKED: begin
                    // An edge on the threshold cycle is still a valid
                    // measurement, so rise is tested before the timeout.
                    if (rise) begin
                        ratio_d  = period_q;
                        valid_d  = 1'b1;
                        period_d = PERIOD_ONE;
                        if ((match_q != '0) && (period_q == o_ratio)) begin
                            if (match_q != LOCK_MATCH) begin
                                match_d = match_q + 1'b1;
                            end
                        end else begin
                            match_d = MATCH_ONE;
                        end
                        state_d = (match_d == LOCK_MATCH) ? LOCKED : MEASURE;
                    end else if (period_q == TIMEOUT_LAST) begin
                        timeout_d = 1'b1;
                        period_d  = '0;
                        match_d   = '0;
                        state_d   = ARM;
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end

                default: begin
                    state_d  = IDLE;
                    period_d = '0;
                    match_d  = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers. o_ratio deliberately holds across enable drops
    // and timeouts so the last good measurement stays visible.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            period_q      <= '0;
            match_q       <= '0;
            o_ratio       <= '0;
            o_ratio_valid <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            period_q      <= period_d;
            match_q       <= match_d;
            o_ratio       <= ratio_d;
            o_ratio_valid <= valid_d;
            o_timeout     <= timeout_d;
        end
    end

    // Lock follows the state, so it drops on the same edge that publishes a
    // mismatching ratio, on a timeout, and one cycle after enable falls.
    assign o_locked = (state_q == LOCKED);

`ifdef CLK_RATIO_DUTY_CHECK_EN
    logic [RATIO_WIDTH-1:0] high_q;
    logic [RATIO_WIDTH-1:0] high_d;
    logic [RATIO_WIDTH:0]   high_time;
    logic [RATIO_WIDTH:0]   half_lo;
    logic [RATIO_WIDTH:0]   half_hi;
    logic                   duty_bad;

    // -----------------------------------------------------------------------
    // High-time counter. It restarts at zero on every edge and only counts
    // the non-edge cycles of a period while the synchronized clock is high.
    // -----------------------------------------------------------------------
    always_comb begin
        high_d = '0;
        if (i_meas_en && ((state_q == MEASURE) || (state_q == LOCKED)) &&
            !rise && (period_q != TIMEOUT_LAST)) begin
            high_d = sync_out ? (high_q + 1'b1) : high_q;
        end
    end

    // -----------------------------------------------------------------------
    // The edge cycle itself is high but was not counted, hence the +1 when
    // forming the true high time. Odd periods accept either neighbour of
    // N/2, so a divider alternating its high time never flags an error.
    // -----------------------------------------------------------------------
    always_comb begin
        high_time = {1'b0, high_q} + 1'b1;
        half_lo   = {1'b0, period_q} >> 1;
        half_hi   = ({1'b0, period_q} + 1'b1) >> 1;
        duty_bad  = (high_time != half_lo) && (high_time != half_hi);
    end

    // -----------------------------------------------------------------------
    // Duty error is published on the same edge as the ratio it belongs to.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            high_q     <= '0;
            o_duty_err <= 1'b0;
        end else begin
            high_q     <= high_d;
            o_duty_err <= valid_d & duty_bad;
        end
    end
`else
    assign o_duty_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_ratio_meter
//
// Directed self-checking bench for clk_ratio_meter with default parameters
// (RATIO_WIDTH=8, LOCK_COUNT=4, SYNC_STAGES=2). The divided clock comes from
// a small pattern generator locked to the reference clock, so every period
// and high time is exact and expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_clk_ratio_meter;

    localparam int LOCK_COUNT = 4;

`ifdef CLK_RATIO_DUTY_CHECK_EN
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif

    logic       i_ref_clk;
    logic       i_rst;
    logic       i_meas_en;
    logic       i_div_clk;
    logic [7:0] o_ratio;
    logic       o_ratio_valid;
    logic       o_locked;
    logic       o_timeout;
    logic       o_duty_err;

    int tests_run = 0;
    int fails     = 0;

    // Divided-clock generator controls
    bit gen_run    = 1'b0;
    int gen_period = 4;
    int gen_high_a = 2;
    int gen_high_b = 2;

    clk_ratio_meter #(
        .RATIO_WIDTH (8),
        .LOCK_COUNT  (LOCK_COUNT),
        .SYNC_STAGES (2)
    ) dut (
        .i_ref_clk     (i_ref_clk),
        .i_rst         (i_rst),
        .i_meas_en     (i_meas_en),
        .i_div_clk     (i_div_clk),
        .o_ratio       (o_ratio),
        .o_ratio_valid (o_ratio_valid),
        .o_locked      (o_locked),
        .o_timeout     (o_timeout),
        .o_duty_err    (o_duty_err)
    );

    initial begin
        i_ref_clk = 1'b0;
        forever #5 i_ref_clk = ~i_ref_clk;
    end

    // Pattern generator: period and high time are latched at the start of
    // each period, high time alternates between gen_high_a and gen_high_b.
    initial begin
        int phase;
        int cur_period;
        int cur_high;
        bit alt;
        phase      = 0;
        cur_period = 4;
        cur_high   = 2;
        alt        = 1'b0;
        i_div_clk  = 1'b0;
        forever begin
            @(posedge i_ref_clk);
            #1;
            if (!gen_run) begin
                i_div_clk = 1'b0;
                phase     = 0;
                alt       = 1'b0;
            end else begin
                if (phase == 0) begin
                    cur_period = gen_period;
                    cur_high   = alt ? gen_high_b : gen_high_a;
                    alt        = ~alt;
                end
                i_div_clk = (phase < cur_high);
                phase     = (phase + 1 == cur_period) ? 0 : phase + 1;
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        i_rst     = 1'b0;
        i_meas_en = 1'b0;
        gen_run   = 1'b0;
        repeat (3) @(negedge i_ref_clk);
        i_rst = 1'b1;
        @(negedge i_ref_clk);
    endtask

    task automatic start_gen(input int period, input int ha, input int hb);
        gen_period = period;
        gen_high_a = ha;
        gen_high_b = hb;
        gen_run    = 1'b1;
    endtask

    // Waits (bounded) for the next o_ratio_valid pulse, sampled on negedges.
    task automatic wait_valid(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge i_ref_clk);
            cycles++;
            if (o_ratio_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int pulses;
        i_rst     = 1'b0;
        i_meas_en = 1'b1;
        start_gen(4, 2, 2);
        repeat (6) @(negedge i_ref_clk);
        tests_run++;
        if (o_ratio !== 8'd0) begin fails++; $display("[TB] FAIL reset_ratio: got %0d want 0", o_ratio); end
        tests_run++;
        if (o_ratio_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", o_ratio_valid); end
        tests_run++;
        if (o_locked !== 1'b0) begin fails++; $display("[TB] FAIL reset_locked: got %b want 0", o_locked); end
        tests_run++;
        if (o_timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout: got %b want 0", o_timeout); end
        tests_run++;
        if (o_duty_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_duty: got %b want 0", o_duty_err); end
        // Out of reset but disabled: the clock toggles, nothing is reported.
        i_meas_en = 1'b0;
        i_rst     = 1'b1;
        pulses    = 0;
        repeat (30) begin
            @(negedge i_ref_clk);
            if (o_ratio_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin fails++; $display("[TB] FAIL idle_no_pulse: got %0d pulses want 0", pulses); end
        gen_run = 1'b0;
    endtask

    task automatic test_steady_ratio(input string tag, input int period, input int ha, input int hb);
        int cyc;
        bit seen;
        bit exp_lock;
        do_reset();
        i_meas_en = 1'b1;
        start_gen(period, ha, hb);
        for (int k = 1; k <= LOCK_COUNT + 1; k++) begin
            wait_valid(4 * period + 8, cyc, seen);
            tests_run++;
            if (!seen) begin
                fails++;
                $display("[TB] FAIL %s_pulse%0d: no valid within %0d cycles", tag, k, 4 * period + 8);
            end else begin
                tests_run++;
                if (o_ratio !== 8'(period)) begin
                    fails++;
                    $display("[TB] FAIL %s_ratio%0d: got %0d want %0d", tag, k, o_ratio, period);
                end
                if (k > 1) begin
                    tests_run++;
                    if (cyc != period) begin
                        fails++;
                        $display("[TB] FAIL %s_interval%0d: got %0d want %0d", tag, k, cyc, period);
                    end
                end
                exp_lock = (k >= LOCK_COUNT);
                tests_run++;
                if (o_locked !== exp_lock) begin
                    fails++;
                    $display("[TB] FAIL %s_locked%0d: got %b want %b", tag, k, o_locked, exp_lock);
                end
                tests_run++;
                if (o_duty_err !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL %s_duty%0d: got %b want 0", tag, k, o_duty_err);
                end
            end
        end
    endtask

    task automatic test_relock();
        int cyc;
        bit seen;
        bit found;
        bit exp_lock;
        do_reset();
        i_meas_en = 1'b1;
        start_gen(6, 3, 3);
        for (int k = 1; k <= LOCK_COUNT; k++) wait_valid(40, cyc, seen);
        tests_run++;
        if (!seen || o_locked !== 1'b1 || o_ratio !== 8'd6) begin
            fails++;
            $display("[TB] FAIL relock_lock6: seen=%b locked=%b ratio=%0d want 1/1/6", seen, o_locked, o_ratio);
        end
        // The period in flight still completes as 6, then the divider runs at 8.
        gen_period = 8;
        gen_high_a = 4;
        gen_high_b = 4;
        found = 1'b0;
        seen  = 1'b1;
        for (int k = 0; k < 3 && !found && seen; k++) begin
            wait_valid(20, cyc, seen);
            if (seen && o_ratio === 8'd8) begin
                found = 1'b1;
            end else if (seen) begin
                tests_run++;
                if (o_ratio !== 8'd6 || o_locked !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL relock_tail6: ratio=%0d locked=%b want 6/1", o_ratio, o_locked);
                end
            end
        end
        tests_run++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL relock_first8: no ratio 8 reported, last ratio %0d", o_ratio);
        end else begin
            tests_run++;
            if (o_locked !== 1'b0) begin
                fails++;
                $display("[TB] FAIL relock_unlock: got locked=%b want 0 with first 8", o_locked);
            end
            for (int j = 2; j <= LOCK_COUNT; j++) begin
                wait_valid(24, cyc, seen);
                exp_lock = (j == LOCK_COUNT);
                tests_run++;
                if (!seen || o_ratio !== 8'd8 || cyc != 8 || o_locked !== exp_lock) begin
                    fails++;
                    $display("[TB] FAIL relock_8_%0d: seen=%b ratio=%0d gap=%0d locked=%b want 1/8/8/%b",
                             j, seen, o_ratio, cyc, o_locked, exp_lock);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int pulses;
        bit seen;
        bit hit;
        do_reset();
        i_meas_en = 1'b1;
        start_gen(8, 4, 4);
        for (int k = 1; k <= LOCK_COUNT; k++) wait_valid(40, cyc, seen);
        tests_run++;
        if (!seen || o_locked !== 1'b1) begin
            fails++;
            $display("[TB] FAIL timeout_prelock: seen=%b locked=%b want 1/1", seen, o_locked);
        end
        // Hold the divided clock low. The last valid edge loaded a count of 1;
        // the count would reach 255 on the 254th following edge.
        gen_run = 1'b0;
        hit     = 1'b0;
        pulses  = 0;
        cyc     = 0;
        while (!hit && cyc < 300) begin
            @(negedge i_ref_clk);
            cyc++;
            if (o_ratio_valid === 1'b1) pulses++;
            if (o_timeout === 1'b1) hit = 1'b1;
        end
        tests_run++;
        if (!hit || cyc != 254) begin
            fails++;
            $display("[TB] FAIL timeout_time: seen=%b after %0d cycles want 1 after 254", hit, cyc);
        end
        tests_run++;
        if (o_locked !== 1'b0) begin fails++; $display("[TB] FAIL timeout_locked: got %b want 0", o_locked); end
        tests_run++;
        if (o_ratio !== 8'd8) begin fails++; $display("[TB] FAIL timeout_hold: got %0d want 8", o_ratio); end
        tests_run++;
        if (pulses != 0) begin fails++; $display("[TB] FAIL timeout_pulses: got %0d want 0", pulses); end
        repeat (5) @(negedge i_ref_clk);
        tests_run++;
        if (o_timeout !== 1'b1) begin fails++; $display("[TB] FAIL timeout_sticky: got %b want 1", o_timeout); end
        i_meas_en = 1'b0;
        @(negedge i_ref_clk);
        tests_run++;
        if (o_timeout !== 1'b0 || o_locked !== 1'b0 || o_ratio !== 8'd8) begin
            fails++;
            $display("[TB] FAIL timeout_disable: timeout=%b locked=%b ratio=%0d want 0/0/8",
                     o_timeout, o_locked, o_ratio);
        end
    endtask

    task automatic test_duty();
        int cyc;
        bit seen;
        do_reset();
        i_meas_en = 1'b1;
        start_gen(6, 1, 1);
        for (int k = 1; k <= LOCK_COUNT; k++) begin
            wait_valid(40, cyc, seen);
            tests_run++;
            if (!seen || o_ratio !== 8'd6 || o_duty_err !== DUTY_ON) begin
                fails++;
                $display("[TB] FAIL duty_pulse%0d: seen=%b ratio=%0d duty=%b want 1/6/%b",
                         k, seen, o_ratio, o_duty_err, DUTY_ON);
            end
        end
        tests_run++;
        if (o_locked !== 1'b1) begin fails++; $display("[TB] FAIL duty_lock: got %b want 1", o_locked); end
        @(negedge i_ref_clk);
        tests_run++;
        if (o_duty_err !== 1'b0) begin fails++; $display("[TB] FAIL duty_width: got %b want 0", o_duty_err); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int edges;
        bit seen;
        bit prev_div;
        do_reset();
        i_meas_en = 1'b1;
        start_gen(4, 2, 2);
        for (int k = 1; k <= LOCK_COUNT; k++) wait_valid(40, cyc, seen);
        tests_run++;
        if (!seen || o_locked !== 1'b1 || o_ratio !== 8'd4) begin
            fails++;
            $display("[TB] FAIL midrst_prelock: seen=%b locked=%b ratio=%0d want 1/1/4", seen, o_locked, o_ratio);
        end
        @(negedge i_ref_clk);
        #1;
        i_rst = 1'b0;
        #1;
        tests_run++;
        if (o_ratio !== 8'd0 || o_locked !== 1'b0 || o_ratio_valid !== 1'b0 ||
            o_timeout !== 1'b0 || o_duty_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_clear: ratio=%0d locked=%b valid=%b timeout=%b duty=%b want all 0",
                     o_ratio, o_locked, o_ratio_valid, o_timeout, o_duty_err);
        end
        repeat (3) @(negedge i_ref_clk);
        cyc = 0;
        while (i_div_clk !== 1'b0 && cyc < 10) begin
            @(negedge i_ref_clk);
            cyc++;
        end
        i_rst    = 1'b1;
        prev_div = 1'b0;
        edges    = 0;
        seen     = 1'b0;
        cyc      = 0;
        while (!seen && cyc < 40) begin
            @(negedge i_ref_clk);
            cyc++;
            if (i_div_clk === 1'b1 && !prev_div) edges++;
            prev_div = i_div_clk;
            if (o_ratio_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || o_ratio !== 8'd4 || edges != 2 || o_locked !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_first: seen=%b ratio=%0d edges=%0d locked=%b want 1/4/2/0",
                     seen, o_ratio, edges, o_locked);
        end
    endtask

    initial begin
        i_rst     = 1'b0;
        i_meas_en = 1'b0;
        test_reset();
        test_steady_ratio("ratio4", 4, 2, 2);
        test_steady_ratio("ratio5", 5, 2, 3);
        test_steady_ratio("ratio2", 2, 1, 1);
        test_relock();
        test_timeout();
        test_duty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
